upcounter: RTL and testbench

Synchronous, parameterized modulo up-counter with load, clear, enable, cascade carry and overflow tracking. It is the up-counting counterpart of the team's ripple down-counter. All bits switch on one clock edge, so downstream logic can sample `count` without ripple skew. It is used as a cycle/event counter and as a prescaler stage when chained through `carry_out`.

---
 rtl/upcounter.sv | 88 ++++++++
 tb/tb_upcounter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upcounter.sv
// Synchronous modulo up-counter with clear, load, enable/cascade carry-in,
// saturate-or-wrap behaviour, sticky overflow and one-cycle event pulses.
module upcounter #(
    parameter int unsigned     WIDTH  = 3,
    parameter longint unsigned MODULO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             sat,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             wrap,
    output logic             ovf,
    output logic             load_err
);

    // One extra bit so MODULO = 2^WIDTH is representable and compares exactly.
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULO);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0]   count_inc;
    logic             at_max;
    logic             load_ok;

    assign count_inc = {1'b0, count_q} + (WIDTH+1)'(1);
    assign at_max    = (count_inc == MOD_W);
    assign load_ok   = ({1'b0, load_val} < MOD_W);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        ovf_d      = ovf_q & ~ovf_clr;

        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (at_max) begin
                // A fresh overflow outranks a concurrent ovf_clr.
                ovf_d = 1'b1;
                if (!sat) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = count_inc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count     = count_q;
    assign carry_out = en & at_max & ~clr & ~load;
    assign wrap      = wrap_q;
    assign ovf       = ovf_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_upcounter.sv
// Scoreboard bench for upcounter: MODULO=8 wrap, MODULO=6 saturate/load/clear,
// asynchronous reset, and a two-stage MODULO=4 cascade.
module tb_upcounter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: WIDTH=3, MODULO=8
    logic       a_clr, a_load, a_en, a_sat, a_ovf_clr;
    logic [2:0] a_load_val, a_count;
    logic       a_carry, a_wrap, a_ovf, a_lerr;

    // Instance B: WIDTH=3, MODULO=6
    logic       b_clr, b_load, b_en, b_sat, b_ovf_clr;
    logic [2:0] b_load_val, b_count;
    logic       b_carry, b_wrap, b_ovf, b_lerr;

    // Cascade: two WIDTH=2, MODULO=4 stages
    logic       c_clr, c_load, c_sat, c_ovf_clr, c0_en;
    logic [1:0] c_load_val, c0_count, c1_count;
    logic       c0_carry, c0_wrap, c0_ovf, c0_lerr;
    logic       c1_carry, c1_wrap, c1_ovf, c1_lerr;

    upcounter #(.WIDTH(3), .MODULO(8)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_load_val),
        .en(a_en), .sat(a_sat), .ovf_clr(a_ovf_clr), .count(a_count),
        .carry_out(a_carry), .wrap(a_wrap), .ovf(a_ovf), .load_err(a_lerr)
    );

    upcounter #(.WIDTH(3), .MODULO(6)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .load_val(b_load_val),
        .en(b_en), .sat(b_sat), .ovf_clr(b_ovf_clr), .count(b_count),
        .carry_out(b_carry), .wrap(b_wrap), .ovf(b_ovf), .load_err(b_lerr)
    );

    upcounter #(.WIDTH(2), .MODULO(4)) u_c0 (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_val(c_load_val),
        .en(c0_en), .sat(c_sat), .ovf_clr(c_ovf_clr), .count(c0_count),
        .carry_out(c0_carry), .wrap(c0_wrap), .ovf(c0_ovf), .load_err(c0_lerr)
    );

    upcounter #(.WIDTH(2), .MODULO(4)) u_c1 (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_val(c_load_val),
        .en(c0_carry), .sat(c_sat), .ovf_clr(c_ovf_clr), .count(c1_count),
        .carry_out(c1_carry), .wrap(c1_wrap), .ovf(c1_ovf), .load_err(c1_lerr)
    );

    typedef struct {
        logic [2:0] cnt;
        logic       wrap;
        logic       ovf;
        logic       lerr;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input logic [2:0] c, input logic w, input logic o, input logic l);
        exp_t e;
        e.cnt = c; e.wrap = w; e.ovf = o; e.lerr = l;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [6:0] obs [4];
        rst_n = 1'b0;
        a_clr = 0; a_load = 0; a_en = 0; a_sat = 0; a_ovf_clr = 0; a_load_val = '0;
        b_clr = 0; b_load = 0; b_en = 0; b_sat = 0; b_ovf_clr = 0; b_load_val = '0;
        c_clr = 0; c_load = 0; c0_en = 0; c_sat = 0; c_ovf_clr = 0; c_load_val = '0;
        #1;
        obs[0] = {a_count, a_wrap, a_ovf, a_lerr, a_carry};
        obs[1] = {b_count, b_wrap, b_ovf, b_lerr, b_carry};
        obs[2] = {1'b0, c0_count, c0_wrap, c0_ovf, c0_lerr, c0_carry};
        obs[3] = {1'b0, c1_count, c1_wrap, c1_ovf, c1_lerr, c1_carry};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs[i] !== 7'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got {cnt,wrap,ovf,lerr,carry}=%b expected 0000000", i, obs[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_en = 1'b1;
            #1;
            vectors++;
            if (a_carry !== (i == 7)) begin
                miscompares++;
                $display("FAIL wrap_carry[%0d]: got %b expected %b", i, a_carry, (i == 7));
            end
            push(3'((i + 1) % 8), (i == 7), (i >= 7), 1'b0);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            vectors++;
            if ({a_count, a_wrap, a_ovf, a_lerr} !== {e.cnt, e.wrap, e.ovf, e.lerr}) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got cnt=%0d w=%b o=%b le=%b expected cnt=%0d w=%b o=%b le=%b",
                         i, a_count, a_wrap, a_ovf, a_lerr, e.cnt, e.wrap, e.ovf, e.lerr);
            end
        end
        @(negedge clk);
        a_en = 1'b0;
    endtask

    task automatic b_step(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({b_count, b_wrap, b_ovf, b_lerr} !== {e.cnt, e.wrap, e.ovf, e.lerr}) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d w=%b o=%b le=%b expected cnt=%0d w=%b o=%b le=%b",
                     name, b_count, b_wrap, b_ovf, b_lerr, e.cnt, e.wrap, e.ovf, e.lerr);
        end
    endtask

    task automatic test_saturate();
        b_sat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_en = 1'b1;
            push((i < 5) ? 3'(i + 1) : 3'd5, 1'b0, (i >= 5), 1'b0);
            b_step("saturate");
        end
        @(negedge clk);
        b_en = 1'b0; b_ovf_clr = 1'b1;
        push(3'd5, 1'b0, 1'b0, 1'b0);
        b_step("ovf_clr");
        @(negedge clk);
        b_ovf_clr = 1'b0;
        push(3'd5, 1'b0, 1'b0, 1'b0);
        b_step("ovf_stays_clear");
        @(negedge clk);
        b_en = 1'b1; b_ovf_clr = 1'b1;
        push(3'd5, 1'b0, 1'b1, 1'b0);
        b_step("ovf_set_wins");
        @(negedge clk);
        b_en = 1'b0; b_ovf_clr = 1'b0; b_sat = 1'b0;
    endtask

    task automatic test_load();
        int ld  [8] = '{1, 0, 1, 0, 1, 1, 1, 0};
        int en  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        int val [8] = '{4, 0, 7, 0, 6, 5, 2, 0};
        int ecnt[8] = '{4, 4, 0, 0, 0, 5, 2, 3};
        int elr [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_load = ld[i][0]; b_en = en[i][0]; b_load_val = 3'(val[i]);
            push(3'(ecnt[i]), 1'b0, 1'b1, elr[i][0]);
            b_step("load");
        end
        @(negedge clk);
        b_load = 1'b0; b_en = 1'b0;
    endtask

    task automatic test_clr_all();
        @(negedge clk);
        b_clr = 1'b1; b_load = 1'b1; b_en = 1'b1; b_load_val = 3'd4;
        push(3'd0, 1'b0, 1'b0, 1'b0);
        b_step("clr_load_en");
        @(negedge clk);
        b_clr = 1'b0; b_en = 1'b0; b_load = 1'b1; b_load_val = 3'd5;
        push(3'd5, 1'b0, 1'b0, 1'b0);
        b_step("load5");
        @(negedge clk);
        b_load = 1'b0; b_en = 1'b1; b_clr = 1'b1;
        #1;
        vectors++;
        if (b_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_masked_clr: got %b expected 0", b_carry);
        end
        b_clr = 1'b0; b_load = 1'b1;
        #1;
        vectors++;
        if (b_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_masked_load: got %b expected 0", b_carry);
        end
        b_load = 1'b0;
        #1;
        vectors++;
        if (b_carry !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_at_max: got %b expected 1", b_carry);
        end
        push(3'd0, 1'b1, 1'b1, 1'b0);
        b_step("wrap6");
        @(negedge clk);
        b_en = 1'b0;
        push(3'd0, 1'b0, 1'b1, 1'b0);
        b_step("wrap_pulse_ends");
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        b_load = 1'b1; b_load_val = 3'd5;
        push(3'd5, 1'b0, 1'b1, 1'b0);
        b_step("preload5");
        @(negedge clk);
        b_load = 1'b0;
        #2;
        rst_n = 1'b0;
        push(3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({b_count, b_wrap, b_ovf, b_lerr, b_carry} !== {e.cnt, e.wrap, e.ovf, e.lerr, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got cnt=%0d w=%b o=%b le=%b co=%b expected all 0",
                     b_count, b_wrap, b_ovf, b_lerr, b_carry);
        end
        @(negedge clk);
        rst_n = 1'b1; b_en = 1'b1;
        push(3'd1, 1'b0, 1'b0, 1'b0);
        b_step("first_after_reset");
        @(negedge clk);
        b_en = 1'b0;
    endtask

    task automatic test_cascade();
        exp_t e0, e1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c0_en = 1'b1;
            #1;
            vectors++;
            if ({c0_carry, c1_carry} !== {(i % 4 == 3), (i % 16 == 15)}) begin
                miscompares++;
                $display("FAIL cascade_carry[%0d]: got c0=%b c1=%b expected c0=%b c1=%b",
                         i, c0_carry, c1_carry, (i % 4 == 3), (i % 16 == 15));
            end
            push(3'((i + 1) % 4), (i % 4 == 3), (i >= 3), 1'b0);
            push(3'(((i + 1) / 4) % 4), (i == 15), (i >= 15), 1'b0);
            @(posedge clk);
            #1;
            e0 = sb.pop_front();
            e1 = sb.pop_front();
            vectors++;
            if ({1'b0, c0_count, c0_wrap, c0_ovf, c0_lerr} !== {e0.cnt, e0.wrap, e0.ovf, e0.lerr}) begin
                miscompares++;
                $display("FAIL cascade_s0[%0d]: got cnt=%0d w=%b o=%b le=%b expected cnt=%0d w=%b o=%b le=%b",
                         i, c0_count, c0_wrap, c0_ovf, c0_lerr, e0.cnt, e0.wrap, e0.ovf, e0.lerr);
            end
            vectors++;
            if ({1'b0, c1_count, c1_wrap, c1_ovf, c1_lerr} !== {e1.cnt, e1.wrap, e1.ovf, e1.lerr}) begin
                miscompares++;
                $display("FAIL cascade_s1[%0d]: got cnt=%0d w=%b o=%b le=%b expected cnt=%0d w=%b o=%b le=%b",
                         i, c1_count, c1_wrap, c1_ovf, c1_lerr, e1.cnt, e1.wrap, e1.ovf, e1.lerr);
            end
        end
        @(negedge clk);
        c0_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_load();
        test_clr_all();
        test_async_reset();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
